// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types for the L1/L2 memory arbiter.
//   lc3b_line        : one cache line (128 bits)
//   mem_arb_state_t  : arbiter FSM states
//   mem_arb_src_t    : which L1 requester owns the L2 port
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int LC3B_LINE_W = 128;

    typedef logic [LC3B_LINE_W-1:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } mem_arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } mem_arb_src_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pick
// Combinational winner select for the L2 port.
// Default build: D has priority unless the starvation counter has reached
// STARVE_MAX while both sides are pending, in which case I wins.
// With MEM_ARB_RR_EN defined: on conflict the side not granted last wins.
// Ports:
//   i_req       in  I-cache request pending
//   d_req       in  D-cache request pending (read or write)
//   starve_cnt  in  consecutive conflicting D grants (default build only)
//   last_grant  in  source of the previous grant (MEM_ARB_RR_EN build only)
//   grant       out chosen source (meaningful only when a request is pending)
// -----------------------------------------------------------------------------
module mem_arbiter_pick
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 3,
    parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic              i_req,
    input  logic              d_req,
`ifdef MEM_ARB_RR_EN
    input  mem_arb_src_t      last_grant,
`else
    input  logic [CNT_W-1:0]  starve_cnt,
`endif
    output mem_arb_src_t      grant
);

    // Winner selection; only a conflict consults the fairness state.
    always_comb begin
        grant = SRC_I;
        if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            if (last_grant == SRC_I) begin
                grant = SRC_D;
            end else begin
                grant = SRC_I;
            end
`else
            if (starve_cnt == CNT_W'(STARVE_MAX)) begin
                grant = SRC_I;
            end else begin
                grant = SRC_D;
            end
`endif
        end else if (d_req) begin
            grant = SRC_D;
        end else begin
            grant = SRC_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single L2 port between the I-cache (read-only) and the D-cache
// (read/write). One line transaction at a time: IDLE picks a winner and
// captures its address/op/data, SERVE_x holds the L2 strobe until l2_resp,
// DONE pulses the winner's resp for one cycle and lets it drop its request.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration instead of
// fixed D priority with a starvation counter.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   i_addr, i_read             I-cache request
//   i_rdata, i_resp            I-cache returned line and completion pulse
//   d_addr, d_read, d_write,
//   d_wdata                    D-cache request (write wins if both set)
//   d_rdata, d_resp            D-cache returned line and completion pulse
//   l2_addr, l2_read, l2_write,
//   l2_wdata                   registered L2 command
//   l2_rdata, l2_resp          L2 returned line and completion
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int LINE_W     = 128,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [ADDR_W-1:0] l2_addr,
    output logic              l2_read,
    output logic              l2_write,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    mem_arb_state_t    state_r;
    mem_arb_state_t    next_state_s;
    mem_arb_src_t      pick_s;
    logic              i_req_s;
    logic              d_req_s;
    logic              grant_s;
    logic              win_d_s;
    logic [ADDR_W-1:0] l2_addr_r;
    logic [LINE_W-1:0] l2_wdata_r;
    logic              l2_read_r;
    logic              l2_write_r;
    logic [LINE_W-1:0] i_rdata_r;
    logic [LINE_W-1:0] d_rdata_r;
    logic              i_resp_r;
    logic              d_resp_r;

    assign i_req_s = i_read;
    assign d_req_s = d_read | d_write;
    // Requests are only sampled in IDLE; everywhere else they are ignored.
    assign grant_s = (state_r == IDLE) && (i_req_s || d_req_s);
    assign win_d_s = (pick_s == SRC_D);

`ifdef MEM_ARB_RR_EN
    mem_arb_src_t last_grant_r;

    // Remember who was granted last so the other side wins the next conflict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_r <= SRC_I;
        end else if (grant_s) begin
            last_grant_r <= pick_s;
        end
    end

    mem_arbiter_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .i_req      (i_req_s),
        .d_req      (d_req_s),
        .last_grant (last_grant_r),
        .grant      (pick_s)
    );
`else
    logic [CNT_W-1:0] starve_cnt_r;

    // Count D grants made while I is waiting; any I grant clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_r <= CNT_W'(0);
        end else if (grant_s) begin
            if (!win_d_s) begin
                starve_cnt_r <= CNT_W'(0);
            end else if (i_req_s && (starve_cnt_r != CNT_W'(STARVE_MAX))) begin
                starve_cnt_r <= starve_cnt_r + CNT_W'(1);
            end
        end
    end

    mem_arbiter_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .i_req      (i_req_s),
        .d_req      (d_req_s),
        .starve_cnt (starve_cnt_r),
        .grant      (pick_s)
    );
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    next_state_s = win_d_s ? SERVE_D : SERVE_I;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SERVE_I, SERVE_D: begin
                if (l2_resp) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = state_r;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Command capture at grant, strobe hold until l2_resp, read-data return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l2_addr_r  <= {ADDR_W{1'b0}};
            l2_wdata_r <= {LINE_W{1'b0}};
            l2_read_r  <= 1'b0;
            l2_write_r <= 1'b0;
            i_rdata_r  <= {LINE_W{1'b0}};
            d_rdata_r  <= {LINE_W{1'b0}};
            i_resp_r   <= 1'b0;
            d_resp_r   <= 1'b0;
        end else begin
            i_resp_r <= 1'b0;
            d_resp_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        l2_addr_r  <= win_d_s ? d_addr : i_addr;
                        // A combined read+write from D is a writeback.
                        l2_write_r <= win_d_s & d_write;
                        l2_read_r  <= ~(win_d_s & d_write);
                        if (win_d_s) begin
                            l2_wdata_r <= d_wdata;
                        end
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (l2_resp) begin
                        l2_read_r  <= 1'b0;
                        l2_write_r <= 1'b0;
                        if (state_r == SERVE_I) begin
                            i_resp_r <= 1'b1;
                            if (l2_read_r) begin
                                i_rdata_r <= l2_rdata;
                            end
                        end else begin
                            d_resp_r <= 1'b1;
                            if (l2_read_r) begin
                                d_rdata_r <= l2_rdata;
                            end
                        end
                    end
                end
                DONE: begin
                    l2_read_r  <= 1'b0;
                    l2_write_r <= 1'b0;
                end
                default: begin
                    l2_read_r  <= 1'b0;
                    l2_write_r <= 1'b0;
                end
            endcase
        end
    end

    assign l2_addr  = l2_addr_r;
    assign l2_wdata = l2_wdata_r;
    assign l2_read  = l2_read_r;
    assign l2_write = l2_write_r;
    assign i_rdata  = i_rdata_r;
    assign d_rdata  = d_rdata_r;
    assign i_resp   = i_resp_r;
    assign d_resp   = d_resp_r;

endmodule
